// File: rtl/adc_3wire_shifter_pkg.sv
// Shared definitions for the ADC 3-wire control-port shifter.
//   state_e    : frame sequencer states
//   PHASE_W    : width of the serial-clock phase counter
//   frame_bits : total bits shifted per register write (address + data)
package adc_3wire_shifter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CLK_HI,
    ST_CLK_LO,
    ST_HOLD,
    ST_GAP
  } state_e;

  localparam int unsigned PHASE_W = 8;

  function automatic int unsigned frame_bits(input int unsigned aw, input int unsigned dw);
    return aw + dw;
  endfunction

endpackage

// File: rtl/adc_3wire_shifter_if.sv
// Register-write request and 3-wire serial port bundle.
//   master : drives start_i/addr_i/data_i, observes status and serial lines
//   slave  : the shifter; consumes the request, drives status and serial lines
interface adc_3wire_shifter_if #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  start_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  ser_clk_o;
  logic                  ser_ldn_o;
  logic                  ser_data_o;

  modport master (
    output start_i, addr_i, data_i,
    input  busy_o, done_o, ser_clk_o, ser_ldn_o, ser_data_o
  );

  modport slave (
    input  start_i, addr_i, data_i,
    output busy_o, done_o, ser_clk_o, ser_ldn_o, ser_data_o
  );
endinterface

// File: rtl/adc_3wire_shifter_tick.sv
// Phase-counter tick generator: tick_o pulses on every CLK_DIV-th cycle.
//   clk, rst     : system clock, synchronous active-high reset
//   restart_i    : zero the phase counter on this edge (state change)
//   tick_o       : current cycle is the last of the phase
//   tick_next_o  : the following cycle will be the last of the phase
module adc_3wire_tick
  import adc_3wire_shifter_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o,
  output logic tick_next_o
);

  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(CLK_DIV - 1);

  logic [PHASE_W-1:0] phase_q, phase_d;

  // Kept separate from the next-phase logic: restart_i depends on tick_o.
  assign tick_o = (phase_q == LAST);

  always_comb begin
    phase_d = phase_q + PHASE_W'(1);
    if (restart_i || tick_o) begin
      phase_d = '0;
    end
    tick_next_o = (phase_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/adc_3wire_shifter.sv
// Shifts one {addr, data} register write MSB-first onto the ADC 3-wire port.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : request (start_i, addr_i, data_i), status (busy_o, done_o),
//              serial port (ser_clk_o, ser_ldn_o active-low, ser_data_o)
// All outputs are registered and derived from the next-state values.
module adc_3wire_shifter
  import adc_3wire_shifter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                clk,
  input  logic                rst,
  adc_3wire_shifter_if.slave  bus
);

  localparam int unsigned N   = frame_bits(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned BCW = $clog2(N + 1);

  state_e         state_q, state_d;
  logic [N-1:0]   shift_q, shift_d;
  logic [BCW-1:0] bit_q, bit_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           sclk_q, sclk_d;
  logic           ldn_q, ldn_d;
  logic           sdata_q, sdata_d;
  logic           tick, tick_next, restart;

  adc_3wire_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .restart_i   (restart),
    .tick_o      (tick),
    .tick_next_o (tick_next)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    unique case (state_q)
      ST_IDLE: if (bus.start_i) begin
        state_d = ST_SETUP;
        shift_d = {bus.addr_i, bus.data_i};
        bit_d   = BCW'(N - 1);
      end
      ST_SETUP: if (tick) state_d = ST_CLK_HI;
      ST_CLK_HI: if (tick) begin
        if (bit_q == '0) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_CLK_LO;
          shift_d = shift_q << 1;
          bit_d   = bit_q - BCW'(1);
        end
      end
      ST_CLK_LO: if (tick) state_d = ST_CLK_HI;
      ST_HOLD:   if (tick) state_d = ST_GAP;
      ST_GAP: if (tick) begin
        state_d = ST_IDLE;
        shift_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign restart = (state_d != state_q);

  // Separate block from next-state logic: tick_next feeds back through restart.
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    ldn_d   = !(state_d inside {ST_SETUP, ST_CLK_HI, ST_CLK_LO, ST_HOLD});
    sclk_d  = (state_d == ST_CLK_HI);
    sdata_d = ldn_d ? 1'b0 : shift_d[N-1];
    done_d  = (state_d == ST_GAP) && tick_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      ldn_q   <= 1'b1;
      sdata_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      ldn_q   <= ldn_d;
      sdata_q <= sdata_d;
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.ser_clk_o  = sclk_q;
  assign bus.ser_ldn_o  = ldn_q;
  assign bus.ser_data_o = sdata_q;

endmodule
